imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Writer side of the 64x32 instruction memory. Receives a program as a byte
//  stream (valid/ready), packs bytes into 32-bit words and writes them through
//  the memory's write port at word index 0..N-1. Holds the MIPS core in reset
//  while loading, then checks an XOR checksum and reports done/err.
// PARAMETERS
//  DEPTH   64  instruction words in memory (max program length)
//  ADDR_W  6   word-index width, = clog2(DEPTH)
//  DATA_W  32  instruction word width (4 bytes)
// PORTS
//  clk        in   1       system clock, rising edge
//  reset      in   1       asynchronous, active-high reset
//  load_start in   1       1-cycle pulse: begin a load (honoured in IDLE/DONE only)
//  rx_data    in   8       incoming byte
//  rx_valid   in   1       rx_data valid
//  rx_ready   out  1       loader accepts byte this cycle
//  mem_we     out  1       instruction-memory write enable (1 cycle per word)
//  mem_addr   out  ADDR_W  word index being written
//  mem_wdata  out  DATA_W  word being written
//  cpu_reset  out  1       holds core in reset while a load is in progress
//  busy       out  1       1 in COUNT/DATA/WRITE/CHECK
//  done       out  1       load finished (sticky until next load_start/reset)
//  err        out  1       bad count or checksum mismatch (valid when done=1)
// BEHAVIOUR
//  - Reset (async): state=IDLE; all outputs 0; word index, byte counter,
//    shift register and checksum cleared. Words already written stay in memory.
//  - Byte handshake: transfer when rx_valid && rx_ready. rx_ready=1 only in
//    COUNT, DATA and CHECK. rx_ready does not depend combinationally on rx_valid.
//  - States and transitions:
//    IDLE : load_start -> COUNT.
//    DONE : load_start -> COUNT. Entering COUNT clears done, err, index, checksum.
//    COUNT: accept 1 byte = N. The value 0 means 64. If N > DEPTH -> DONE with
//           err=1 and no writes. Otherwise -> DATA. The count byte is excluded
//           from the checksum.
//    DATA : accept bytes MSB first into the shift register; byte counter 0..3.
//           Every data byte is XORed into the checksum. The 4th byte -> WRITE.
//    WRITE: exactly 1 cycle: mem_we=1, mem_addr=index, mem_wdata=packed word.
//           Then index+1. If index+1==N -> CHECK, else -> DATA.
//    CHECK: accept 1 byte. done=1; err=(byte != checksum). -> DONE.
//  - Latency: 4th byte accepted at edge t -> mem_we high in cycle t+1.
//    No byte is accepted during WRITE.
//  - Outputs: mem_we is 0 outside WRITE. mem_addr/mem_wdata hold their last
//    value when mem_we=0. cpu_reset=busy, registered.
//  - load_start while busy is ignored. Stalls on rx_valid=0 are unlimited; there is
//    no timeout.
//  - Index never wraps: the largest address written is N-1 <= 63.
//  - Reset mid-load returns to IDLE immediately; partial words are discarded.
// TESTING
//  1. N=1, bytes 20 08 00 05, chk 2D -> one mem_we, addr 0, wdata 0x20080005,
//     then done=1 err=0 cpu_reset=0.
//  2. N=0x00, 256 bytes, correct chk -> 64 writes, addr 0..63 in order, err=0.
//  3. N=0x41 -> done=1 err=1, mem_we never asserted, cpu_reset back to 0.
//  4. N=2, valid data, chk wrong -> 2 writes performed, done=1 err=1.
//  5. rx_valid held high continuously -> rx_ready=0 in each WRITE cycle; no byte
//     lost or duplicated; random rx_valid gaps give identical words.
//  6. Async reset after 2 DATA bytes -> all outputs 0 at once; a new load with
//     N=1 starts at addr 0; load_start pulsed mid-load is ignored.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream, instruction-memory write and status signals of the imem loader.
// The loader takes the slave modport; whoever feeds it a program takes the master modport.
interface imem_loader_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              load_start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output load_start, rx_data, rx_valid,
        input  rx_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done, err
    );

    modport slave (
        input  load_start, rx_data, rx_valid,
        output rx_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// Loads a byte-streamed program into the instruction memory (count byte, MSB-first
// data words, XOR checksum byte) while holding the core in reset.
module imem_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int CNT_W = $clog2(BYTES);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_DATA, S_WRITE, S_CHECK, S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] index;
    logic [ADDR_W:0]   count;
    logic [CNT_W-1:0]  byte_cnt;
    logic [DATA_W-1:0] shreg;
    logic [7:0]        chksum;

    logic              take;
    logic [8:0]        n_rx;
    logic [ADDR_W:0]   index_inc;
    logic [DATA_W-1:0] word_next;

    // NOTE: every variable written in this always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        take      = bus.rx_valid && bus.rx_ready;
        n_rx      = (bus.rx_data == 8'd0) ? 9'(DEPTH) : {1'b0, bus.rx_data};
        index_inc = {1'b0, index} + (ADDR_W + 1)'(1);
        word_next = {shreg[DATA_W-9:0], bus.rx_data};
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            index         <= '0;
            count         <= '0;
            byte_cnt      <= '0;
            shreg         <= '0;
            chksum        <= '0;
            bus.rx_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.cpu_reset <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            bus.mem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.load_start) begin
                        state         <= S_COUNT;
                        index         <= '0;
                        byte_cnt      <= '0;
                        chksum        <= '0;
                        bus.rx_ready  <= 1'b1;
                        bus.busy      <= 1'b1;
                        bus.cpu_reset <= 1'b1;
                        bus.done      <= 1'b0;
                        bus.err       <= 1'b0;
                    end
                end
                S_COUNT: begin
                    if (take) begin
                        if (n_rx > 9'(DEPTH)) begin
                            // Oversized program: finish at once without touching memory.
                            state         <= S_DONE;
                            bus.rx_ready  <= 1'b0;
                            bus.busy      <= 1'b0;
                            bus.cpu_reset <= 1'b0;
                            bus.done      <= 1'b1;
                            bus.err       <= 1'b1;
                        end else begin
                            count <= n_rx[ADDR_W:0];
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (take) begin
                        shreg  <= word_next;
                        chksum <= chksum ^ bus.rx_data;
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt      <= '0;
                            state         <= S_WRITE;
                            bus.rx_ready  <= 1'b0;
                            bus.mem_we    <= 1'b1;
                            bus.mem_addr  <= index;
                            bus.mem_wdata <= word_next;
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end
                end
                S_WRITE: begin
                    index        <= index_inc[ADDR_W-1:0];
                    bus.rx_ready <= 1'b1;
                    state        <= (index_inc == count) ? S_CHECK : S_DATA;
                end
                S_CHECK: begin
                    if (take) begin
                        state         <= S_DONE;
                        bus.rx_ready  <= 1'b0;
                        bus.busy      <= 1'b0;
                        bus.cpu_reset <= 1'b0;
                        bus.done      <= 1'b1;
                        bus.err       <= (bus.rx_data != chksum);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
